// File: rtl/mode_selector_sync.sv
// Synchronises, debounces and latches N_MODES one-hot mode switches; flags conflicts,
// honours a lock input and pulses mode_change for one cycle on every accepted change.
module mode_selector_sync #(
  parameter  int N_MODES         = 3,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int IDX_W           = $clog2(N_MODES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_MODES-1:0] switch_in,
  input  logic               lock,
  output logic [N_MODES-1:0] mode,
  output logic [IDX_W-1:0]   mode_idx,
  output logic               mode_valid,
  output logic               mode_change,
  output logic               conflict
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // 0 = no bits set, 1 = exactly one bit set, 2 = two or more bits set
  function automatic logic [1:0] pop_class(input logic [N_MODES-1:0] v);
    logic [1:0] c;
    c = 2'd0;
    for (int i = 0; i < N_MODES; i++) begin
      if (v[i]) c = (c == 2'd0) ? 2'd1 : 2'd2;
    end
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [N_MODES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_MODES; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  logic [N_MODES-1:0] sw_meta_q, sw_sync_q;
  logic [N_MODES-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_MODES-1:0] stable_q, stable_d;
  logic [N_MODES-1:0] mode_q, mode_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               change_q, change_d;
  logic               conflict_q, conflict_d;
  logic [1:0]         pc;

  // Debounce: the whole vector must hold unchanged before it becomes the stable vector
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sw_sync_q != cand_q) begin
      cand_d = sw_sync_q;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      stable_d = cand_q;
    end
  end

  // Decision: only a lone set bit that differs from the current mode is accepted
  always_comb begin
    pc         = pop_class(stable_q);
    mode_d     = mode_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    change_d   = 1'b0;
    conflict_d = (pc == 2'd2);
    if ((pc == 2'd1) && !lock && (stable_q != mode_q)) begin
      mode_d   = stable_q;
      idx_d    = onehot_idx(stable_q);
      valid_d  = 1'b1;
      change_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      stable_q   <= '0;
      mode_q     <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      change_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      sw_meta_q  <= switch_in;
      sw_sync_q  <= sw_meta_q;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      change_q   <= change_d;
      conflict_q <= conflict_d;
    end
  end

  assign mode        = mode_q;
  assign mode_idx    = idx_q;
  assign mode_valid  = valid_q;
  assign mode_change = change_q;
  assign conflict    = conflict_q;

endmodule
